// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// Holds the lock-state enum, default sizes and the pointer wrap helper.
package mux_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    localparam int unsigned DEF_BIT_WIDTH  = 16;
    localparam int unsigned DEF_NUM_INPUTS = 6;
    localparam int unsigned DEF_SEL_WIDTH  = 3;

    // Next round-robin start index: idx + 1, wrapping to 0 past n - 1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational rotate-priority encoder: first valid index at or after i_ptr,
// wrapping from NUM_INPUTS-1 back to 0.
module mux_arb_rr_pick
    import mux_arb_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic [NUM_INPUTS-1:0] i_valid,
    input  logic [SEL_WIDTH-1:0]  i_ptr,
    output logic [SEL_WIDTH-1:0]  o_winner,
    output logic [NUM_INPUTS-1:0] o_grant,
    output logic                  o_any_valid
);

    int unsigned          w_idx;
    logic [SEL_WIDTH-1:0] w_sel;

    always_comb begin
        o_winner    = '0;
        o_grant     = '0;
        o_any_valid = 1'b0;
        w_idx       = 32'd0;
        w_sel       = '0;
        for (int unsigned off = 0; off < NUM_INPUTS; off++) begin
            w_idx = 32'(i_ptr) + off;
            if (w_idx >= NUM_INPUTS) begin
                w_idx = w_idx - NUM_INPUTS;
            end
            w_sel = SEL_WIDTH'(w_idx);
            if (!o_any_valid && i_valid[w_sel]) begin
                o_any_valid    = 1'b1;
                o_winner       = w_sel;
                o_grant[w_sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding one registered NUM_INPUTS:1 mux output stage.
// Define MUX_ARB_LOCK_EN to hold the grant on a requester until its i_req_last beat.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
    parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_INPUTS-1:0]           i_req_valid,
    input  logic [NUM_INPUTS*BIT_WIDTH-1:0] i_req_data,
    input  logic [NUM_INPUTS-1:0]           i_req_last,
    output logic [NUM_INPUTS-1:0]           o_req_ready,
    output logic                            o_valid,
    output logic [BIT_WIDTH-1:0]            o_data,
    output logic [SEL_WIDTH-1:0]            o_sel,
    input  logic                            i_ready
);

    logic                  r_valid;
    logic [BIT_WIDTH-1:0]  r_data;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [SEL_WIDTH-1:0]  r_ptr;

    logic [NUM_INPUTS-1:0] w_pick_valid;
    logic [NUM_INPUTS-1:0] w_grant;
    logic [SEL_WIDTH-1:0]  w_winner;
    logic                  w_any;
    logic                  w_free;
    logic                  w_xfer;
    logic [BIT_WIDTH-1:0]  w_mux_data;

    assign w_free = !r_valid || i_ready;
    assign w_xfer = rst_n && w_free && w_any;

`ifdef MUX_ARB_LOCK_EN
    arb_state_e            r_state;
    arb_state_e            w_state_next;
    logic [SEL_WIDTH-1:0]  r_lock_idx;
    logic [SEL_WIDTH-1:0]  w_lock_idx_next;
    logic [NUM_INPUTS-1:0] w_lock_mask;

    // While locked, only the lock owner is visible to the encoder.
    always_comb begin
        w_lock_mask             = '0;
        w_lock_mask[r_lock_idx] = 1'b1;
        w_pick_valid = (r_state == ARB_LOCKED) ? (i_req_valid & w_lock_mask) : i_req_valid;
    end

    always_comb begin
        w_state_next    = r_state;
        w_lock_idx_next = r_lock_idx;
        if (w_xfer) begin
            case (r_state)
                ARB_IDLE: begin
                    if (!i_req_last[w_winner]) begin
                        w_state_next    = ARB_LOCKED;
                        w_lock_idx_next = w_winner;
                    end
                end
                ARB_LOCKED: begin
                    if (i_req_last[w_winner]) begin
                        w_state_next = ARB_IDLE;
                    end
                end
                default: w_state_next = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_lock_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_lock_idx <= w_lock_idx_next;
        end
    end
`else
    logic w_unused_last;
    assign w_unused_last = ^i_req_last;
    assign w_pick_valid  = i_req_valid;
`endif

    mux_arb_rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_pick (
        .i_valid     (w_pick_valid),
        .i_ptr       (r_ptr),
        .o_winner    (w_winner),
        .o_grant     (w_grant),
        .o_any_valid (w_any)
    );

    always_comb begin
        w_mux_data = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (w_winner == SEL_WIDTH'(i)) begin
                w_mux_data = i_req_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign o_req_ready = (rst_n && w_free) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_free) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_mux_data;
                r_sel   <= w_winner;
                r_ptr   <= SEL_WIDTH'(wrap_inc(32'(w_winner), NUM_INPUTS));
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, lock sequences
// and a randomized phase against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int unsigned BW = 16;
    localparam int unsigned NI = 6;
    localparam int unsigned SW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NI-1:0]    i_req_valid;
    logic [NI*BW-1:0] i_req_data;
    logic [NI-1:0]    i_req_last;
    logic [NI-1:0]    o_req_ready;
    logic             o_valid;
    logic [BW-1:0]    o_data;
    logic [SW-1:0]    o_sel;
    logic             i_ready;

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .BIT_WIDTH  (BW),
        .NUM_INPUTS (NI),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_sel       (o_sel),
        .i_ready     (i_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [NI-1:0] valid;
        logic          ready;
        logic [NI-1:0] grant;
        logic          ovalid;
        logic [BW-1:0] odata;
        logic [SW-1:0] osel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [NI-1:0] v, input logic r, input logic [NI-1:0] g,
                                input logic ov, input logic [BW-1:0] od, input logic [SW-1:0] os);
        vec_t e;
        e.valid = v; e.ready = r; e.grant = g; e.ovalid = ov; e.odata = od; e.osel = os;
        tbl.push_back(e);
    endfunction

    task automatic set_pattern_data();
        for (int i = 0; i < NI; i++) i_req_data[i*BW +: BW] = BW'(i * 16'h1111);
    endtask

    // Drive one cycle of inputs, check grant mid-cycle and the output register after the edge.
    task automatic cycle(input logic [NI-1:0] v, input logic r, input logic [NI-1:0] last,
                         input logic [NI-1:0] eg, input logic ev, input logic [BW-1:0] ed,
                         input logic [SW-1:0] es, input string tag);
        i_req_valid = v;
        i_ready     = r;
        i_req_last  = last;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(o_req_ready), 32'(eg));
        @(posedge clk);
        #1;
        chk({tag, ".o_valid"}, 32'(o_valid), 32'(ev));
        chk({tag, ".o_data"}, 32'(o_data), 32'(ed));
        chk({tag, ".o_sel"}, 32'(o_sel), 32'(es));
    endtask

    task automatic do_reset(input int cycles);
        rst_n       = 1'b0;
        i_req_valid = '1;
        i_req_last  = '1;
        i_ready     = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk("reset.req_ready", 32'(o_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("reset.o_valid", 32'(o_valid), 32'd0);
        chk("reset.o_data", 32'(o_data), 32'd0);
        chk("reset.o_sel", 32'(o_sel), 32'd0);
        rst_n = 1'b1;
    endtask

    // Behavioural reference model state.
    int          m_ptr;
    bit          m_valid;
    logic [BW-1:0] m_data;
    int          m_sel;
    bit          m_locked;
    int          m_lock_idx;

    function automatic logic [NI-1:0] m_grant();
        int idx;
        if (!rst_n || (m_valid && !i_ready)) return '0;
        for (int k = 0; k < NI; k++) begin
            idx = (m_ptr + k) % NI;
            if (i_req_valid[idx] && (!m_locked || idx == m_lock_idx)) return NI'(1) << idx;
        end
        return '0;
    endfunction

    function automatic void m_update(input logic [NI-1:0] g);
        int idx = 0;
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0; m_locked = 0; m_lock_idx = 0;
        end else if (!m_valid || i_ready) begin
            if (g != '0) begin
                for (int i = 0; i < NI; i++) if (g[i]) idx = i;
                m_valid = 1;
                m_data  = i_req_data[idx*BW +: BW];
                m_sel   = idx;
                m_ptr   = (idx + 1) % NI;
`ifdef MUX_ARB_LOCK_EN
                if (!m_locked) begin
                    if (!i_req_last[idx]) begin
                        m_locked   = 1;
                        m_lock_idx = idx;
                    end
                end else if (i_req_last[idx]) begin
                    m_locked = 0;
                end
`endif
            end else begin
                m_valid = 0;
            end
        end
    endfunction

    initial begin
        logic [NI-1:0] eg;
        rst_n       = 1'b0;
        i_req_valid = '0;
        i_req_last  = '1;
        i_ready     = 1'b1;
        i_req_data  = '0;
        set_pattern_data();

        do_reset(2);

        for (int k = 0; k < 7; k++) begin
            add(6'h3F, 1'b1, NI'(1) << (k % NI), 1'b1, BW'((k % NI) * 16'h1111), SW'(k % NI));
        end
        for (int k = 0; k < 5; k++) add(6'h08, 1'b1, 6'h08, 1'b1, 16'h3333, 3'd3);
        add(6'h3F, 1'b1, 6'h10, 1'b1, 16'h4444, 3'd4);
        add(6'h00, 1'b1, 6'h00, 1'b0, 16'h4444, 3'd4);
        add(6'h04, 1'b1, 6'h04, 1'b1, 16'h2222, 3'd2);
        for (int k = 0; k < 3; k++) add(6'h3F, 1'b0, 6'h00, 1'b1, 16'h2222, 3'd2);
        add(6'h3F, 1'b1, 6'h08, 1'b1, 16'h3333, 3'd3);
        add(6'h00, 1'b0, 6'h00, 1'b1, 16'h3333, 3'd3);
        add(6'h00, 1'b1, 6'h00, 1'b0, 16'h3333, 3'd3);
        add(6'h01, 1'b0, 6'h01, 1'b1, 16'h0000, 3'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].valid, tbl[i].ready, '1, tbl[i].grant, tbl[i].ovalid,
                  tbl[i].odata, tbl[i].osel, $sformatf("tbl%0d", i));
        end

        // Burst from requester 1 with last on its third beat, requester 2 competing.
        do_reset(1);
        cycle(6'h06, 1'b1, 6'h00, 6'h02, 1'b1, 16'h1111, 3'd1, "burst0");
`ifdef MUX_ARB_LOCK_EN
        cycle(6'h06, 1'b1, 6'h00, 6'h02, 1'b1, 16'h1111, 3'd1, "burst1");
        cycle(6'h06, 1'b1, 6'h02, 6'h02, 1'b1, 16'h1111, 3'd1, "burst2");
`else
        cycle(6'h06, 1'b1, 6'h00, 6'h04, 1'b1, 16'h2222, 3'd2, "burst1");
        cycle(6'h06, 1'b1, 6'h02, 6'h02, 1'b1, 16'h1111, 3'd1, "burst2");
`endif
        cycle(6'h06, 1'b1, 6'h00, 6'h04, 1'b1, 16'h2222, 3'd2, "burst3");

        // Lock owner drops valid, then reset mid-lock must release it.
        do_reset(1);
        cycle(6'h06, 1'b1, 6'h00, 6'h02, 1'b1, 16'h1111, 3'd1, "midlock0");
`ifdef MUX_ARB_LOCK_EN
        cycle(6'h04, 1'b1, 6'h00, 6'h00, 1'b0, 16'h1111, 3'd1, "midlock1");
`else
        cycle(6'h04, 1'b1, 6'h00, 6'h04, 1'b1, 16'h2222, 3'd2, "midlock1");
`endif
        do_reset(1);
        cycle(6'h04, 1'b1, 6'h04, 6'h04, 1'b1, 16'h2222, 3'd2, "postrst0");
        cycle(6'h06, 1'b1, 6'h06, 6'h02, 1'b1, 16'h1111, 3'd1, "postrst1");

        // Randomized phase; first cycle is a reset so the model starts in sync.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = (n == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            i_req_valid = ($urandom_range(0, 3) == 0) ? '1 : NI'($urandom);
            i_req_last  = NI'($urandom);
            i_ready     = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NI; i++) i_req_data[i*BW +: BW] = BW'($urandom);
            @(negedge clk);
            eg = m_grant();
            chk("rand.req_ready", 32'(o_req_ready), 32'(eg));
            @(posedge clk);
            m_update(eg);
            #1;
            chk("rand.o_valid", 32'(o_valid), 32'(m_valid));
            chk("rand.o_data", 32'(o_data), 32'(m_data));
            chk("rand.o_sel", 32'(o_sel), 32'(m_sel));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer that shares one registered NUM_INPUTS:1 mux datapath between NUM_INPUTS independent requesters. Each requester presents a BIT_WIDTH word with a valid/ready handshake. The block picks one winner per cycle, drives the mux select, and loads the selected word into a single registered output stage that the downstream consumer drains with valid/ready. It sits in front of the 6:1 mux test datapath and replaces the free-running `i_sel` with arbitrated selection.

## Interface
- BIT_WIDTH, 16, width of each requester word
- NUM_INPUTS, 6, number of requesters (2..8)
- SEL_WIDTH, 3, width of the select/index; must satisfy 2^SEL_WIDTH >= NUM_INPUTS
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- i_req_valid  in  NUM_INPUTS  per-requester valid
- i_req_data  in  NUM_INPUTS*BIT_WIDTH  requester i occupies bits [i*BIT_WIDTH +: BIT_WIDTH]
- i_req_last  in  NUM_INPUTS  end-of-burst marker; used only when MUX_ARB_LOCK_EN is defined
- o_req_ready  out  NUM_INPUTS  one-hot grant; a transfer occurs when valid and ready are both high
- o_valid  out  1  output register holds a word
- o_data  out  BIT_WIDTH  registered mux output
- o_sel  out  SEL_WIDTH  index of the requester whose word is in o_data
- i_ready  in  1  downstream accept

## Operation
- The output stage is free when o_valid is 0 or i_ready is 1.
- When the stage is free and any i_req_valid is set:
  - Winner = first valid index at or after ptr, scanning upward and wrapping from NUM_INPUTS-1 to 0.
  - o_req_ready[winner] is 1; all other bits are 0.
  - On the clock edge: o_data <= winner's word, o_sel <= winner, o_valid <= 1, ptr <= winner+1 (wrapping to 0 after NUM_INPUTS-1).
- When the stage is free and no requester is valid: o_valid <= 0. o_data and o_sel hold their values.
- When the stage is not free: o_req_ready is all-zero, and o_valid, o_data, o_sel and ptr hold.
- o_req_ready is combinational from i_req_valid, ptr, lock state and i_ready. Requesters must not make valid depend on ready.
- Valid bits at indices >= NUM_INPUTS do not exist. ptr never exceeds NUM_INPUTS-1.
- Lock FSM (only when MUX_ARB_LOCK_EN is defined):
  - States are IDLE and LOCKED, with a lock_idx register.
  - IDLE -> LOCKED: on a transfer with i_req_last[winner] = 0. lock_idx <= winner.
  - LOCKED: only lock_idx may be granted. Other requesters are ignored even if lock_idx drops valid.
  - LOCKED -> IDLE: on a transfer from lock_idx with i_req_last = 1.
  - ptr updates on every transfer as above.
- Reset (rst_n low at a rising edge):
  - o_valid=0, o_data=0, o_sel=0, ptr=0, FSM=IDLE, lock_idx=0.
  - o_req_ready is forced to all-zero while rst_n is low.
  - Reset mid-burst or mid-backpressure discards the held word and any lock.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on o_data/o_valid after edge N.
- Throughput is one word per cycle while i_ready stays high.
- Fairness: with all requesters continuously valid and no lock, each requester is granted exactly once every NUM_INPUTS cycles.
- Simultaneous downstream accept and new grant in the same cycle is required to give full throughput.
- The first grant after reset goes to the lowest valid index.

## Configuration
- MUX_ARB_LOCK_EN:
  - Defined: the IDLE/LOCKED FSM is present and i_req_last is honoured.
  - Undefined: there is no FSM, i_req_last is ignored, and every transfer is arbitrated independently.

## Structure
- Package mux_arb_pkg holds:
  - The lock-state enum (ARB_IDLE, ARB_LOCKED).
  - Default BIT_WIDTH, NUM_INPUTS and SEL_WIDTH constants.
  - The wrap-increment function used for ptr.
- Sub-module mux_arb_rr_pick is a combinational rotate-priority encoder. Inputs: valid vector and ptr. Outputs: winner index, one-hot grant, any_valid.
- The top level holds ptr, the output register, the lock FSM and the data mux.

## Test plan
- Reset: hold rst_n low for 2 cycles with all valid high -> o_valid=0, o_data=0x0000, o_sel=0, o_req_ready=6'b000000.
- Full rotation: all 6 requesters valid with data i*0x1111, i_ready=1 -> o_data 0x0000, 0x1111, …, 0x5555 with o_sel 0..5 on consecutive cycles, then 0x0000/o_sel=0 again (wrap).
- Single requester: only index 3 valid for 5 cycles -> 5 consecutive grants, o_sel=3 each cycle, ptr=4 afterward.
- Backpressure: o_valid=1 with o_data=0x2222 and i_ready=0 for 3 cycles -> o_data, o_sel and ptr hold, o_req_ready=0. Raise i_ready -> the next word (index 3) appears one cycle later.
- Lock (MUX_ARB_LOCK_EN defined): requesters 1 and 2 valid, requester 1 sends 3 beats with last on the 3rd -> o_sel=1,1,1 then 2. Without the macro -> o_sel=1,2,1,…
- Reset mid-lock: rst_n low for 1 cycle while LOCKED on index 1 -> next grant goes to the lowest valid index, and the lock is released.
